// File: rtl/udp_arb_pkg.sv
// Purpose: shared types and constants for the UDP TX arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package udp_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_META,
    ARB_DATA
  } udp_arb_state_t;

  localparam int UDP_TX_META_WIDTH = 176;

endpackage

// File: rtl/udp_tx_arbiter_rr_pick.sv
// Purpose: rotating-priority encoder; first set req bit at or after ptr, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none.
// Ports: req (request vector), ptr (start index), gnt_idx (winner), any (some request set).
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  int j;

  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    j       = 0;
    for (int i = 0; i < N; i++) begin
      // ptr is always < N, so one subtraction is enough to wrap.
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any     = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Purpose: packet-granular round-robin share of the udp_stack TX meta+data path among N_PORTS requesters.
// Latency: 1 cycle grant decision in IDLE; meta and data then pass through with zero latency.
// Backpressure: m_*_ready is routed only to the owner; all other ports (and the owner's data in META) see ready=0.
// Ports: net_clk/net_areset; s_meta_* / s_data_* per-requester slave streams (packed, port i at slice i);
//        m_meta_* / m_data_* master streams to udp_stack; grant_idx, busy, pkt_count status.
module udp_tx_arbiter
  import udp_arb_pkg::*;
#(
  parameter  int N_PORTS    = 4,
  parameter  int WIDTH      = 64,
  parameter  int META_WIDTH = UDP_TX_META_WIDTH,
  parameter  int CNT_WIDTH  = 32,
  localparam int IW         = $clog2(N_PORTS),
  localparam int KW         = WIDTH / 8
) (
  input  logic                            net_clk,
  input  logic                            net_areset,
  input  logic [N_PORTS-1:0]              s_meta_valid,
  output logic [N_PORTS-1:0]              s_meta_ready,
  input  logic [N_PORTS*META_WIDTH-1:0]   s_meta_data,
  input  logic [N_PORTS-1:0]              s_data_valid,
  output logic [N_PORTS-1:0]              s_data_ready,
  input  logic [N_PORTS*WIDTH-1:0]        s_data_data,
  input  logic [N_PORTS*KW-1:0]           s_data_keep,
  input  logic [N_PORTS-1:0]              s_data_last,
  output logic                            m_meta_valid,
  input  logic                            m_meta_ready,
  output logic [META_WIDTH-1:0]           m_meta_data,
  output logic                            m_data_valid,
  input  logic                            m_data_ready,
  output logic [WIDTH-1:0]                m_data_data,
  output logic [KW-1:0]                   m_data_keep,
  output logic                            m_data_last,
  output logic [IW-1:0]                   grant_idx,
  output logic                            busy,
  output logic [N_PORTS*CNT_WIDTH-1:0]    pkt_count
);

  udp_arb_state_t        state_q, state_d;
  logic [IW-1:0]         grant_q, grant_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0]  cnt_q [N_PORTS];
  logic [N_PORTS-1:0]    cnt_inc;

  logic [IW-1:0]         pick_idx;
  logic                  pick_any;

  // Per-port views of the packed input buses so the owner can be selected by index.
  logic [META_WIDTH-1:0] meta_arr [N_PORTS];
  logic [WIDTH-1:0]      data_arr [N_PORTS];
  logic [KW-1:0]         keep_arr [N_PORTS];

  for (genvar g = 0; g < N_PORTS; g++) begin : g_port
    assign meta_arr[g]                          = s_meta_data[g*META_WIDTH +: META_WIDTH];
    assign data_arr[g]                          = s_data_data[g*WIDTH +: WIDTH];
    assign keep_arr[g]                          = s_data_keep[g*KW +: KW];
    assign pkt_count[g*CNT_WIDTH +: CNT_WIDTH]  = cnt_q[g];
  end

  rr_pick #(.N(N_PORTS)) u_pick (
    .req     (s_meta_valid),
    .ptr     (rr_ptr_q),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Payload fields follow the owner at all times; only valid/ready are state-gated.
  assign m_meta_data = meta_arr[grant_q];
  assign m_data_data = data_arr[grant_q];
  assign m_data_keep = keep_arr[grant_q];
  assign m_data_last = s_data_last[grant_q];
  assign grant_idx   = grant_q;
  assign busy        = (state_q != ARB_IDLE);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_inc      = '0;
    m_meta_valid = 1'b0;
    m_data_valid = 1'b0;
    s_meta_ready = '0;
    s_data_ready = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = ARB_META;
        end
      end
      ARB_META: begin
        m_meta_valid          = s_meta_valid[grant_q];
        s_meta_ready[grant_q] = m_meta_ready;
        if (s_meta_valid[grant_q] && m_meta_ready) state_d = ARB_DATA;
      end
      ARB_DATA: begin
        m_data_valid          = s_data_valid[grant_q];
        s_data_ready[grant_q] = m_data_ready;
        if (s_data_valid[grant_q] && m_data_ready && s_data_last[grant_q]) begin
          state_d           = ARB_IDLE;
          cnt_inc[grant_q]  = 1'b1;
          // Next scan starts just after the port that finished, giving round-robin fairness.
          rr_ptr_d = (grant_q == IW'(N_PORTS - 1)) ? '0 : grant_q + IW'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge net_clk or posedge net_areset) begin
    if (net_areset) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      for (int i = 0; i < N_PORTS; i++) cnt_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < N_PORTS; i++) begin
        if (cnt_inc[i]) cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Purpose: self-checking bench for udp_tx_arbiter with per-port sources and a scoreboard.
// Latency: n/a.
// Backpressure: sink readiness is bench-controlled to exercise stalls.
module tb_udp_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int MW = 176;
  localparam int KW = 8;
  localparam int CW = 4;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic              net_clk;
  logic              net_areset;
  logic [N-1:0]      s_meta_valid, s_meta_ready, s_data_valid, s_data_ready, s_data_last;
  logic [N*MW-1:0]   s_meta_data;
  logic [N*W-1:0]    s_data_data;
  logic [N*KW-1:0]   s_data_keep;
  logic              m_meta_valid, m_meta_ready, m_data_valid, m_data_ready, m_data_last;
  logic [MW-1:0]     m_meta_data;
  logic [W-1:0]      m_data_data;
  logic [KW-1:0]     m_data_keep;
  logic [1:0]        grant_idx;
  logic              busy;
  logic [N*CW-1:0]   pkt_count;

  udp_tx_arbiter #(.N_PORTS(N), .WIDTH(W), .META_WIDTH(MW), .CNT_WIDTH(CW)) dut (
    .net_clk(net_clk), .net_areset(net_areset),
    .s_meta_valid(s_meta_valid), .s_meta_ready(s_meta_ready), .s_meta_data(s_meta_data),
    .s_data_valid(s_data_valid), .s_data_ready(s_data_ready), .s_data_data(s_data_data),
    .s_data_keep(s_data_keep), .s_data_last(s_data_last),
    .m_meta_valid(m_meta_valid), .m_meta_ready(m_meta_ready), .m_meta_data(m_meta_data),
    .m_data_valid(m_data_valid), .m_data_ready(m_data_ready), .m_data_data(m_data_data),
    .m_data_keep(m_data_keep), .m_data_last(m_data_last),
    .grant_idx(grant_idx), .busy(busy), .pkt_count(pkt_count)
  );

  initial net_clk = 1'b0;
  always #5 net_clk = ~net_clk;

  // Sources present queue heads; expected queues are filled at the same moment.
  logic [MW-1:0] src_meta [N][$];
  beat_t         src_beat [N][$];
  logic [MW-1:0] exp_meta [N][$];
  beat_t         exp_beat [N][$];
  logic [CW-1:0] exp_cnt  [N];
  logic [N-1:0]  meta_hold;
  logic          sink_meta_rdy, sink_data_rdy;
  int            grant_log[$];
  int            hs_cyc[$];
  int            cyc, seq, n_cmp, n_bad;

  function automatic logic [MW-1:0] rand_meta();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[MW-1:0];
  endfunction

  function automatic bit pending();
    for (int i = 0; i < N; i++)
      if (src_meta[i].size() != 0 || src_beat[i].size() != 0 ||
          exp_meta[i].size() != 0 || exp_beat[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic send_pkt(input int p, input int nb, input logic [MW-1:0] meta);
    beat_t bt;
    src_meta[p].push_back(meta);
    exp_meta[p].push_back(meta);
    for (int b = 0; b < nb; b++) begin
      bt.data = {8'(p), 8'(b), 16'(seq), $urandom};
      bt.keep = (b == nb - 1) ? 8'($urandom_range(1, 255)) : 8'hFF;
      bt.last = (b == nb - 1);
      src_beat[p].push_back(bt);
      exp_beat[p].push_back(bt);
    end
    seq++;
    exp_cnt[p] = exp_cnt[p] + 1'b1;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      s_meta_valid[i]            = (src_meta[i].size() != 0) && !meta_hold[i];
      s_meta_data[i*MW +: MW]    = (src_meta[i].size() != 0) ? src_meta[i][0] : '0;
      s_data_valid[i]            = (src_beat[i].size() != 0);
      s_data_data[i*W +: W]      = (src_beat[i].size() != 0) ? src_beat[i][0].data : '0;
      s_data_keep[i*KW +: KW]    = (src_beat[i].size() != 0) ? src_beat[i][0].keep : '0;
      s_data_last[i]             = (src_beat[i].size() != 0) ? src_beat[i][0].last : 1'b0;
    end
    m_meta_ready = sink_meta_rdy;
    m_data_ready = sink_data_rdy;
  endtask

  // One clock: observe at negedge (scoreboard pops), then drive new inputs after the edge.
  task automatic cycle();
    int g;
    beat_t e;
    logic [MW-1:0] em;
    @(negedge net_clk);
    cyc++;
    g = int'(grant_idx);
    n_cmp++;
    for (int i = 0; i < N; i++) begin
      if ((s_meta_ready[i] || s_data_ready[i]) && (!busy || g != i)) begin
        n_bad++;
        $display("FAIL ready_leak: port %0d meta_rdy=%0b data_rdy=%0b busy=%0b owner=%0d, required 0", i, s_meta_ready[i], s_data_ready[i], busy, g);
      end
    end
    if (m_meta_valid && m_meta_ready) begin
      grant_log.push_back(g);
      hs_cyc.push_back(cyc);
      n_cmp++;
      if (exp_meta[g].size() == 0) begin
        n_bad++;
        $display("FAIL meta_extra: port %0d got %0h with nothing expected", g, m_meta_data);
      end else begin
        em = exp_meta[g].pop_front();
        if (m_meta_data !== em) begin
          n_bad++;
          $display("FAIL meta_data: port %0d got %0h expected %0h", g, m_meta_data, em);
        end
      end
    end
    if (m_data_valid && m_data_ready) begin
      n_cmp++;
      if (exp_beat[g].size() == 0) begin
        n_bad++;
        $display("FAIL beat_extra: port %0d got %0h with nothing expected", g, m_data_data);
      end else begin
        e = exp_beat[g].pop_front();
        if ({m_data_data, m_data_keep, m_data_last} !== e) begin
          n_bad++;
          $display("FAIL beat: port %0d got %0h/%0h/%0b expected %0h/%0h/%0b", g, m_data_data, m_data_keep, m_data_last, e.data, e.keep, e.last);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (s_meta_valid[i] && s_meta_ready[i]) void'(src_meta[i].pop_front());
      if (s_data_valid[i] && s_data_ready[i]) void'(src_beat[i].pop_front());
    end
    @(posedge net_clk);
    #1;
    drive_inputs();
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (pending() && n < budget) begin
      cycle();
      n++;
    end
    n_cmp++;
    if (pending()) begin
      n_bad++;
      $display("FAIL drain_timeout: traffic still pending after %0d cycles, required none", budget);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      src_meta[i].delete(); src_beat[i].delete();
      exp_meta[i].delete(); exp_beat[i].delete();
      exp_cnt[i] = '0;
    end
    meta_hold = '0;
    sink_meta_rdy = 1'b1;
    sink_data_rdy = 1'b1;
  endtask

  task automatic do_reset();
    net_areset = 1'b1;
    clear_all();
    drive_inputs();
    repeat (2) @(posedge net_clk);
    #1;
    net_areset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    net_areset   = 1'b1;
    clear_all();
    drive_inputs();
    s_meta_valid = '1;
    s_data_valid = '1;
    repeat (3) @(posedge net_clk);
    #2;
    n_cmp++;
    if ({busy, grant_idx, m_meta_valid, m_data_valid} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_state: busy=%0b grant=%0d mv=%0b dv=%0b, required all 0", busy, grant_idx, m_meta_valid, m_data_valid);
    end
    n_cmp++;
    if ({s_meta_ready, s_data_ready} !== '0) begin
      n_bad++;
      $display("FAIL reset_ready: got %0h, required 0", {s_meta_ready, s_data_ready});
    end
    n_cmp++;
    if (pkt_count !== '0) begin
      n_bad++;
      $display("FAIL reset_count: got %0h, required 0", pkt_count);
    end
    do_reset();
  endtask

  task automatic test_single_port();
    grant_log.delete();
    send_pkt(2, 3, {22{8'hAB}});
    drive_inputs();
    #1;
    n_cmp++;
    if (busy !== 1'b0 || m_meta_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_cycle: busy=%0b mv=%0b, required 0/0", busy, m_meta_valid);
    end
    cycle();
    n_cmp++;
    if (busy !== 1'b1 || grant_idx !== 2'd2 || m_meta_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL grant_p2: busy=%0b grant=%0d mv=%0b, required 1/2/1", busy, grant_idx, m_meta_valid);
    end
    drain(50);
    n_cmp++;
    if (pkt_count[2*CW +: CW] !== 4'd1) begin
      n_bad++;
      $display("FAIL count_p2: got %0d, required 1", pkt_count[2*CW +: CW]);
    end
    // Round-robin pointer should now sit at 3: port 3 beats port 0.
    send_pkt(0, 1, rand_meta());
    send_pkt(3, 1, rand_meta());
    drive_inputs();
    #1;
    drain(50);
    n_cmp++;
    if (grant_log.size() != 3 || grant_log[0] != 2 || grant_log[1] != 3 || grant_log[2] != 0) begin
      n_bad++;
      $display("FAIL rr_after_p2: got order %p, required '{2,3,0}", grant_log);
    end
  endtask

  task automatic test_all_ports();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    grant_log.delete();
    hs_cyc.delete();
    for (int p = 0; p < N; p++) send_pkt(p, 1, rand_meta());
    send_pkt(0, 1, rand_meta());
    drive_inputs();
    #1;
    drain(60);
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (k >= grant_log.size() || grant_log[k] != exp_order[k]) begin
        n_bad++;
        $display("FAIL grant_order[%0d]: got %p, required %p", k, grant_log, exp_order);
      end
    end
    for (int k = 1; k < 5 && k < hs_cyc.size(); k++) begin
      n_cmp++;
      if (hs_cyc[k] - hs_cyc[k-1] != 3) begin
        n_bad++;
        $display("FAIL pkt_cycles[%0d]: got %0d, required 3", k, hs_cyc[k] - hs_cyc[k-1]);
      end
    end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (pkt_count[i*CW +: CW] !== exp_cnt[i]) begin
        n_bad++;
        $display("FAIL count_all[%0d]: got %0d, required %0d", i, pkt_count[i*CW +: CW], exp_cnt[i]);
      end
    end
  endtask

  task automatic test_stall();
    int n = 0;
    logic [W-1:0] held;
    send_pkt(1, 4, rand_meta());
    drive_inputs();
    #1;
    while (exp_beat[1].size() > 3 && n < 40) begin
      cycle();
      n++;
    end
    n_cmp++;
    if (exp_beat[1].size() != 3) begin
      n_bad++;
      $display("FAIL stall_setup: %0d beats left, required 3", exp_beat[1].size());
    end
    sink_data_rdy = 1'b0;
    send_pkt(0, 1, rand_meta());
    send_pkt(3, 2, rand_meta());
    drive_inputs();
    #1;
    held = m_data_data;
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_cmp++;
      if (m_data_valid !== 1'b1 || m_data_data !== held || grant_idx !== 2'd1 ||
          s_meta_ready !== 4'b0 || s_data_ready !== 4'b0) begin
        n_bad++;
        $display("FAIL stall[%0d]: dv=%0b data=%0h grant=%0d mr=%0h dr=%0h, required 1/%0h/1/0/0", k, m_data_valid, m_data_data, grant_idx, s_meta_ready, s_data_ready, held);
      end
    end
    sink_data_rdy = 1'b1;
    drive_inputs();
    #1;
    drain(80);
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (pkt_count[i*CW +: CW] !== exp_cnt[i]) begin
        n_bad++;
        $display("FAIL count_stall[%0d]: got %0d, required %0d", i, pkt_count[i*CW +: CW], exp_cnt[i]);
      end
    end
  endtask

  task automatic test_early_data();
    meta_hold[0] = 1'b1;
    send_pkt(0, 3, rand_meta());
    drive_inputs();
    #1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_cmp++;
      if (s_data_valid[0] !== 1'b1 || s_data_ready[0] !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL early_idle[%0d]: dvalid=%0b drdy=%0b busy=%0b, required 1/0/0", k, s_data_valid[0], s_data_ready[0], busy);
      end
    end
    meta_hold[0]  = 1'b0;
    sink_meta_rdy = 1'b0;
    drive_inputs();
    #1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_cmp++;
      if (s_data_ready[0] !== 1'b0 || m_data_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL early_meta[%0d]: drdy=%0b m_dv=%0b, required 0/0", k, s_data_ready[0], m_data_valid);
      end
    end
    n_cmp++;
    if (busy !== 1'b1 || grant_idx !== 2'd0 || m_meta_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL early_grant: busy=%0b grant=%0d mv=%0b, required 1/0/1", busy, grant_idx, m_meta_valid);
    end
    sink_meta_rdy = 1'b1;
    drive_inputs();
    #1;
    drain(40);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    send_pkt(2, 4, rand_meta());
    drive_inputs();
    #1;
    while (exp_beat[2].size() > 2 && n < 40) begin
      cycle();
      n++;
    end
    n_cmp++;
    if (busy !== 1'b1 || m_data_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL midpkt_setup: busy=%0b dv=%0b, required 1/1", busy, m_data_valid);
    end
    net_areset = 1'b1;
    #1;
    n_cmp++;
    if ({busy, m_meta_valid, m_data_valid, s_meta_ready, s_data_ready} !== '0 || pkt_count !== '0 || grant_idx !== 2'd0) begin
      n_bad++;
      $display("FAIL async_reset: busy=%0b mv=%0b dv=%0b mr=%0h dr=%0h cnt=%0h grant=%0d, required all 0", busy, m_meta_valid, m_data_valid, s_meta_ready, s_data_ready, pkt_count, grant_idx);
    end
    clear_all();
    drive_inputs();
    @(posedge net_clk);
    #1;
    net_areset = 1'b0;
    grant_log.delete();
    send_pkt(1, 1, rand_meta());
    send_pkt(0, 2, rand_meta());
    drive_inputs();
    #1;
    drain(40);
    n_cmp++;
    if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1) begin
      n_bad++;
      $display("FAIL post_reset_order: got %p, required '{0,1}", grant_log);
    end
  endtask

  task automatic test_wrap();
    send_pkt(3, 1, rand_meta());
    for (int k = 0; k < 14; k++) send_pkt(1, 1, rand_meta());
    drive_inputs();
    #1;
    drain(200);
    n_cmp++;
    if (pkt_count[1*CW +: CW] !== 4'hF) begin
      n_bad++;
      $display("FAIL pre_wrap: got %0d, required 15", pkt_count[1*CW +: CW]);
    end
    send_pkt(1, 2, rand_meta());
    drive_inputs();
    #1;
    drain(40);
    n_cmp++;
    if (pkt_count[1*CW +: CW] !== 4'h0) begin
      n_bad++;
      $display("FAIL wrap: got %0d, required 0", pkt_count[1*CW +: CW]);
    end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (pkt_count[i*CW +: CW] !== exp_cnt[i]) begin
        n_bad++;
        $display("FAIL count_wrap[%0d]: got %0d, required %0d", i, pkt_count[i*CW +: CW], exp_cnt[i]);
      end
    end
  endtask

  initial begin
    cyc = 0; seq = 0; n_cmp = 0; n_bad = 0;
    net_areset    = 1'b1;
    s_meta_valid  = '0; s_meta_data = '0;
    s_data_valid  = '0; s_data_data = '0; s_data_keep = '0; s_data_last = '0;
    m_meta_ready  = 1'b0; m_data_ready = 1'b0;
    test_reset();
    test_single_port();
    test_all_ports();
    test_stall();
    test_early_data();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
